mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one downstream memory port between the two Ibex memory interfaces: instruction fetch and load/store data.
- Both upstream ports and the downstream port use the Ibex req/gnt/rvalid protocol.
- Sits between ibex_top and the on-chip RAM/bus bridge in the processor block.
- Tracks in-flight requests in order so each response (rvalid/rdata/err) returns to the master that issued it.

Parameters:
- MAX_OUTSTANDING, 2, max granted-but-unanswered downstream transactions; integer 1..8.
- DATA_PRIORITY, 1, 1 = data port wins every conflict; 0 = round-robin between instr and data.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-low reset
- instr_req_i / instr_gnt_o / instr_rvalid_o  in/out/out  1 each  instruction handshake
- instr_addr_i  in  32  fetch address
- instr_rdata_o  out  32  fetch data
- instr_rdata_intg_o  out  7  fetch data integrity
- instr_err_o  out  1  fetch error
- data_req_i / data_gnt_o / data_rvalid_o  in/out/out  1 each  data handshake
- data_we_i  in  1  write enable
- data_be_i  in  4  byte enables
- data_addr_i  in  32  data address
- data_wdata_i  in  32  write data
- data_wdata_intg_i  in  7  write data integrity
- data_rdata_o  out  32  read data
- data_rdata_intg_o  out  7  read data integrity
- data_err_o  out  1  data error
- mem_req_o / mem_gnt_i / mem_rvalid_i  out/in/in  1 each  downstream handshake
- mem_we_o  out  1  write enable
- mem_be_o  out  4  byte enables
- mem_addr_o  out  32  address
- mem_wdata_o  out  32  write data
- mem_wdata_intg_o  out  7  write data integrity
- mem_rdata_i  in  32  read data
- mem_rdata_intg_i  in  7  read data integrity
- mem_err_i  in  1  bus error
- protocol_err_o  out  1  sticky: response with no outstanding request

Behaviour:
- Reset (rst low at posedge): outstanding FIFO emptied, lock cleared, round-robin pointer = instr, protocol_err_o = 0. All handshake outputs are forced 0 while rst is low.
- Grant eligibility: a master's request is eligible only when FIFO count < MAX_OUTSTANDING.
  - FIFO full blocks new grants even if a pop happens in the same cycle.
- Selection:
  - If only one master requests, it is selected.
  - On conflict: DATA_PRIORITY=1 selects data. DATA_PRIORITY=0 selects the master the pointer names, and the pointer flips to the other master after each accepted transfer.
- Forwarding: the selected master's req/we/be/addr/wdata/wdata_intg drive mem_* combinationally (0-cycle latency). For an instr selection: mem_we_o=0, mem_be_o=4'hF, mem_wdata_o=0, mem_wdata_intg_o=0.
- Lock:
  - If mem_req_o=1 and mem_gnt_i=0, the selection is registered and held the next cycle regardless of the other master. The downstream sees a stable request until gnt.
  - The lock clears on the cycle mem_gnt_i=1.
  - If the locked master drops req (protocol violation), mem_req_o follows it low and the lock clears.
- Grant routing: mem_gnt_i is routed only to the selected master's gnt_o; the other gnt_o = 0. On mem_req_o & mem_gnt_i, push the master ID into the FIFO.
- Response routing:
  - On mem_rvalid_i, pop the FIFO head and assert that master's rvalid_o with rdata/rdata_intg/err.
  - The non-addressed master sees rvalid=0; its rdata is don't-care and driven 0.
  - Responses are in order. The earliest legal rvalid is the cycle after gnt; same-cycle gnt+rvalid for the same transfer is not supported.
- Simultaneous push and pop (count < max): count unchanged, FIFO order preserved.
- Response with FIFO empty: dropped (no rvalid_o), protocol_err_o set, held until reset.
- Reset mid-transaction: in-flight responses are discarded. Any rvalid arriving after reset with an empty FIFO sets protocol_err_o. The downstream must be reset together with the arbiter.

Decomposition:
- Package mem_arb_pkg:
  - typedef enum logic {MST_INSTR, MST_DATA} mst_id_e
  - localparams MEM_AW=32, MEM_DW=32, MEM_INTGW=7
  - localparam MAX_OUTSTANDING_LIMIT=8
- Sub-module mem_arb_id_fifo: parameterised-depth FIFO of mst_id_e with push/pop/count/full/empty and a synchronous active-low reset on rst. The top level holds the selection/lock logic and muxing.

Test Plan:
- Instr-only fetches to 0x0, 0x4 with mem_gnt_i=1, rvalid 1 cycle later returning 0x00000013 -> instr_rvalid_o pulses twice with 0x00000013; data_rvalid_o stays 0.
- Both request same cycle, DATA_PRIORITY=1 -> data granted first; instr granted the next cycle; responses return to data then instr.
- DATA_PRIORITY=0, both request continuously for 4 transfers -> grants alternate instr, data, instr, data.
- mem_gnt_i held 0 for 3 cycles while data is selected and instr requests meanwhile -> mem_addr_o stays at the data address until gnt.
- MAX_OUTSTANDING=2, grants at cycles 1 and 2 with no rvalid -> cycle 3 gnt_o=0 even with mem_gnt_i=1. rvalid at cycle 4 -> grant resumes at cycle 5.
- Pulse mem_rvalid_i with FIFO empty -> no rvalid_o; protocol_err_o=1 until rst low.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and sizes for the instruction/data memory port arbiter.
package mem_arb_pkg;

  typedef enum logic {MST_INSTR, MST_DATA} mst_id_e;

  localparam int MEM_AW                = 32;
  localparam int MEM_DW                = 32;
  localparam int MEM_INTGW             = 7;
  localparam int MAX_OUTSTANDING_LIMIT = 8;

endpackage

// File: rtl/mem_arb_id_fifo.sv
// In-order record of which master owns each granted, unanswered transaction.
module mem_arb_id_fifo
  import mem_arb_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  mst_id_e          push_id,
  input  logic             pop,
  output mst_id_e          head,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  mst_id_e          slots [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_next(wr_ptr);
      if (pop)  rd_ptr <= ptr_next(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Slot contents are only meaningful between push and pop, so they carry no reset.
  always_ff @(posedge clk) begin
    if (push) slots[wr_ptr] <= push_id;
  end

  assign head  = slots[rd_ptr];
  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one req/gnt/rvalid memory port between the Ibex fetch and load/store
// interfaces, routing in-order responses back to the master that issued them.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 2,
  parameter bit DATA_PRIORITY   = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        instr_req_i,
  output logic        instr_gnt_o,
  output logic        instr_rvalid_o,
  input  logic [31:0] instr_addr_i,
  output logic [31:0] instr_rdata_o,
  output logic [6:0]  instr_rdata_intg_o,
  output logic        instr_err_o,
  input  logic        data_req_i,
  output logic        data_gnt_o,
  output logic        data_rvalid_o,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_wdata_i,
  input  logic [6:0]  data_wdata_intg_i,
  output logic [31:0] data_rdata_o,
  output logic [6:0]  data_rdata_intg_o,
  output logic        data_err_o,
  output logic        mem_req_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic [6:0]  mem_wdata_intg_o,
  input  logic [31:0] mem_rdata_i,
  input  logic [6:0]  mem_rdata_intg_i,
  input  logic        mem_err_i,
  output logic        protocol_err_o
);

  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

  mst_id_e          sel;
  mst_id_e          lock_id;
  mst_id_e          rr_ptr;
  mst_id_e          head;
  logic             lock;
  logic             proto_err;
  logic             eligible;
  logic             xfer;
  logic             resp;
  logic             pop;
  logic             push;
  logic [CNT_W-1:0] count;
  logic             full;
  logic             empty;

  // A full FIFO blocks new grants even when a response frees a slot this cycle.
  assign eligible = (count < CNT_W'(MAX_OUTSTANDING));

  always_comb begin
    sel       = MST_INSTR;
    mem_req_o = 1'b0;
    if (lock) begin
      sel       = lock_id;
      mem_req_o = (lock_id == MST_DATA) ? data_req_i : instr_req_i;
    end else if (eligible) begin
      if (instr_req_i && data_req_i) begin
        sel = DATA_PRIORITY ? MST_DATA : rr_ptr;
      end else if (data_req_i) begin
        sel = MST_DATA;
      end
      mem_req_o = instr_req_i || data_req_i;
    end
    if (!rst) mem_req_o = 1'b0;
  end

  always_comb begin
    if (sel == MST_DATA) begin
      mem_we_o         = data_we_i;
      mem_be_o         = data_be_i;
      mem_addr_o       = data_addr_i;
      mem_wdata_o      = data_wdata_i;
      mem_wdata_intg_o = data_wdata_intg_i;
    end else begin
      mem_we_o         = 1'b0;
      mem_be_o         = 4'hF;
      mem_addr_o       = instr_addr_i;
      mem_wdata_o      = '0;
      mem_wdata_intg_o = '0;
    end
  end

  assign xfer        = mem_req_o && mem_gnt_i;
  assign push        = xfer && !full;
  assign instr_gnt_o = xfer && (sel == MST_INSTR);
  assign data_gnt_o  = xfer && (sel == MST_DATA);

  assign resp = rst && mem_rvalid_i;
  assign pop  = resp && !empty;

  assign instr_rvalid_o     = pop && (head == MST_INSTR);
  assign instr_rdata_o      = instr_rvalid_o ? mem_rdata_i : '0;
  assign instr_rdata_intg_o = instr_rvalid_o ? mem_rdata_intg_i : '0;
  assign instr_err_o        = instr_rvalid_o && mem_err_i;
  assign data_rvalid_o      = pop && (head == MST_DATA);
  assign data_rdata_o       = data_rvalid_o ? mem_rdata_i : '0;
  assign data_rdata_intg_o  = data_rvalid_o ? mem_rdata_intg_i : '0;
  assign data_err_o         = data_rvalid_o && mem_err_i;
  assign protocol_err_o     = proto_err;

  // A stalled request holds its selection; a dropped request releases it.
  always_ff @(posedge clk) begin
    if (!rst) begin
      lock      <= 1'b0;
      lock_id   <= MST_INSTR;
      rr_ptr    <= MST_INSTR;
      proto_err <= 1'b0;
    end else begin
      lock    <= mem_req_o && !mem_gnt_i;
      lock_id <= sel;
      if (xfer) rr_ptr <= (sel == MST_INSTR) ? MST_DATA : MST_INSTR;
      if (resp && empty) proto_err <= 1'b1;
    end
  end

  mem_arb_id_fifo #(
    .DEPTH(MAX_OUTSTANDING)
  ) u_id_fifo (
    .clk    (clk),
    .rst    (rst),
    .push   (push),
    .push_id(sel),
    .pop    (pop),
    .head   (head),
    .count  (count),
    .full   (full),
    .empty  (empty)
  );

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench: a data-priority instance and a round-robin instance share stimulus.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_req;
  logic [31:0] instr_addr;
  logic        data_req;
  logic        data_we;
  logic [3:0]  data_be;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic [6:0]  data_wdata_intg;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic [6:0]  mem_rdata_intg;
  logic        mem_err;

  logic        instr_gnt, instr_rvalid, instr_err, data_gnt, data_rvalid, data_err;
  logic [31:0] instr_rdata, data_rdata;
  logic [6:0]  instr_rdata_intg, data_rdata_intg;
  logic        mem_req, mem_we, protocol_err;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr, mem_wdata;
  logic [6:0]  mem_wdata_intg;

  logic        r_instr_gnt, r_instr_rvalid, r_instr_err, r_data_gnt, r_data_rvalid, r_data_err;
  logic [31:0] r_instr_rdata, r_data_rdata;
  logic [6:0]  r_instr_rdata_intg, r_data_rdata_intg;
  logic        r_mem_req, r_mem_we, r_protocol_err;
  logic [3:0]  r_mem_be;
  logic [31:0] r_mem_addr, r_mem_wdata;
  logic [6:0]  r_mem_wdata_intg;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.MAX_OUTSTANDING(2), .DATA_PRIORITY(1'b1)) dut (
    .clk(clk), .rst(rst),
    .instr_req_i(instr_req), .instr_gnt_o(instr_gnt), .instr_rvalid_o(instr_rvalid),
    .instr_addr_i(instr_addr), .instr_rdata_o(instr_rdata),
    .instr_rdata_intg_o(instr_rdata_intg), .instr_err_o(instr_err),
    .data_req_i(data_req), .data_gnt_o(data_gnt), .data_rvalid_o(data_rvalid),
    .data_we_i(data_we), .data_be_i(data_be), .data_addr_i(data_addr),
    .data_wdata_i(data_wdata), .data_wdata_intg_i(data_wdata_intg),
    .data_rdata_o(data_rdata), .data_rdata_intg_o(data_rdata_intg), .data_err_o(data_err),
    .mem_req_o(mem_req), .mem_gnt_i(mem_gnt), .mem_rvalid_i(mem_rvalid),
    .mem_we_o(mem_we), .mem_be_o(mem_be), .mem_addr_o(mem_addr),
    .mem_wdata_o(mem_wdata), .mem_wdata_intg_o(mem_wdata_intg),
    .mem_rdata_i(mem_rdata), .mem_rdata_intg_i(mem_rdata_intg), .mem_err_i(mem_err),
    .protocol_err_o(protocol_err)
  );

  mem_port_arbiter #(.MAX_OUTSTANDING(2), .DATA_PRIORITY(1'b0)) dut_rr (
    .clk(clk), .rst(rst),
    .instr_req_i(instr_req), .instr_gnt_o(r_instr_gnt), .instr_rvalid_o(r_instr_rvalid),
    .instr_addr_i(instr_addr), .instr_rdata_o(r_instr_rdata),
    .instr_rdata_intg_o(r_instr_rdata_intg), .instr_err_o(r_instr_err),
    .data_req_i(data_req), .data_gnt_o(r_data_gnt), .data_rvalid_o(r_data_rvalid),
    .data_we_i(data_we), .data_be_i(data_be), .data_addr_i(data_addr),
    .data_wdata_i(data_wdata), .data_wdata_intg_i(data_wdata_intg),
    .data_rdata_o(r_data_rdata), .data_rdata_intg_o(r_data_rdata_intg), .data_err_o(r_data_err),
    .mem_req_o(r_mem_req), .mem_gnt_i(mem_gnt), .mem_rvalid_i(mem_rvalid),
    .mem_we_o(r_mem_we), .mem_be_o(r_mem_be), .mem_addr_o(r_mem_addr),
    .mem_wdata_o(r_mem_wdata), .mem_wdata_intg_o(r_mem_wdata_intg),
    .mem_rdata_i(mem_rdata), .mem_rdata_intg_i(mem_rdata_intg), .mem_err_i(mem_err),
    .protocol_err_o(r_protocol_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic idle();
    instr_req = 0; instr_addr = '0; data_req = 0; data_we = 0; data_be = '0;
    data_addr = '0; data_wdata = '0; data_wdata_intg = '0; mem_gnt = 0;
    mem_rvalid = 0; mem_rdata = '0; mem_rdata_intg = '0; mem_err = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 0;
    idle();
    step();
    // Handshake outputs forced low while reset is held, even with live inputs.
    instr_req = 1; mem_gnt = 1; mem_rvalid = 1;
    smp();
    chk("rst_mem_req", mem_req, 0);
    chk("rst_instr_gnt", instr_gnt, 0);
    chk("rst_instr_rvalid", instr_rvalid, 0);
    step();
    smp();
    chk("rst_proto_err", protocol_err, 0);
    step(); rst = 1; idle();

    // Instruction-only fetches.
    step(); instr_req = 1; instr_addr = 32'h0; mem_gnt = 1;
    smp();
    chk("f0_mem_req", mem_req, 1);
    chk("f0_addr", mem_addr, 32'h0);
    chk("f0_gnt", instr_gnt, 1);
    chk("f0_we", mem_we, 0);
    chk("f0_be", mem_be, 4'hF);
    step(); instr_addr = 32'h4; mem_rvalid = 1; mem_rdata = 32'h13;
    smp();
    chk("f1_addr", mem_addr, 32'h4);
    chk("f1_gnt", instr_gnt, 1);
    chk("f1_rvalid", instr_rvalid, 1);
    chk("f1_rdata", instr_rdata, 32'h13);
    chk("f1_data_rvalid", data_rvalid, 0);
    step(); instr_req = 0; mem_gnt = 0;
    smp();
    chk("f2_rvalid", instr_rvalid, 1);
    chk("f2_rdata", instr_rdata, 32'h13);
    chk("f2_data_rvalid", data_rvalid, 0);
    step(); idle();
    smp();
    chk("f3_rvalid", instr_rvalid, 0);
    chk("f3_proto", protocol_err, 0);

    // Conflict with data priority.
    step();
    instr_req = 1; instr_addr = 32'h100;
    data_req = 1; data_we = 1; data_be = 4'h3; data_addr = 32'h200;
    data_wdata = 32'hDEADBEEF; data_wdata_intg = 7'h55; mem_gnt = 1;
    smp();
    chk("dp_data_gnt", data_gnt, 1);
    chk("dp_instr_gnt", instr_gnt, 0);
    chk("dp_addr", mem_addr, 32'h200);
    chk("dp_we", mem_we, 1);
    chk("dp_be", mem_be, 4'h3);
    chk("dp_wdata", mem_wdata, 32'hDEADBEEF);
    chk("dp_wintg", mem_wdata_intg, 7'h55);
    step(); data_req = 0;
    smp();
    chk("dp2_instr_gnt", instr_gnt, 1);
    chk("dp2_addr", mem_addr, 32'h100);
    chk("dp2_we", mem_we, 0);
    chk("dp2_be", mem_be, 4'hF);
    chk("dp2_wdata", mem_wdata, 32'h0);
    step(); instr_req = 0; mem_gnt = 0;
    mem_rvalid = 1; mem_rdata = 32'hAAAA0001; mem_rdata_intg = 7'h11; mem_err = 1;
    smp();
    chk("dp_r1_data_rvalid", data_rvalid, 1);
    chk("dp_r1_data_rdata", data_rdata, 32'hAAAA0001);
    chk("dp_r1_data_intg", data_rdata_intg, 7'h11);
    chk("dp_r1_data_err", data_err, 1);
    chk("dp_r1_instr_rvalid", instr_rvalid, 0);
    chk("dp_r1_instr_rdata", instr_rdata, 32'h0);
    step(); mem_rdata = 32'hBBBB0002; mem_err = 0;
    smp();
    chk("dp_r2_instr_rvalid", instr_rvalid, 1);
    chk("dp_r2_instr_rdata", instr_rdata, 32'hBBBB0002);
    chk("dp_r2_data_rvalid", data_rvalid, 0);
    step(); idle();

    // Round-robin: fresh reset so the pointer names instr.
    rst = 0;
    step(); rst = 1;
    step(); instr_req = 1; instr_addr = 32'h500; data_req = 1; data_addr = 32'h600; mem_gnt = 1;
    smp();
    chk("rr1_instr_gnt", r_instr_gnt, 1);
    chk("rr1_data_gnt", r_data_gnt, 0);
    chk("rr1_addr", r_mem_addr, 32'h500);
    chk("rr1_dp_data_gnt", data_gnt, 1);
    step(); mem_rvalid = 1; mem_rdata = 32'h1;
    smp();
    chk("rr2_data_gnt", r_data_gnt, 1);
    chk("rr2_addr", r_mem_addr, 32'h600);
    chk("rr2_instr_rvalid", r_instr_rvalid, 1);
    step();
    smp();
    chk("rr3_instr_gnt", r_instr_gnt, 1);
    chk("rr3_data_rvalid", r_data_rvalid, 1);
    step();
    smp();
    chk("rr4_data_gnt", r_data_gnt, 1);
    chk("rr4_instr_rvalid", r_instr_rvalid, 1);
    step(); instr_req = 0; data_req = 0; mem_gnt = 0;
    smp();
    chk("rr5_data_rvalid", r_data_rvalid, 1);
    step(); idle();

    // Stalled data request holds the port while instr arrives.
    step(); data_req = 1; data_addr = 32'h300;
    smp();
    chk("lk1_addr", r_mem_addr, 32'h300);
    chk("lk1_gnt", r_data_gnt, 0);
    step(); instr_req = 1; instr_addr = 32'h400;
    smp();
    chk("lk2_rr_addr", r_mem_addr, 32'h300);
    chk("lk2_dp_addr", mem_addr, 32'h300);
    chk("lk2_instr_gnt", r_instr_gnt, 0);
    step();
    smp();
    chk("lk3_rr_addr", r_mem_addr, 32'h300);
    step(); mem_gnt = 1;
    smp();
    chk("lk4_data_gnt", r_data_gnt, 1);
    chk("lk4_instr_gnt", r_instr_gnt, 0);
    chk("lk4_addr", r_mem_addr, 32'h300);
    step(); data_req = 0;
    smp();
    chk("lk5_instr_gnt", r_instr_gnt, 1);
    chk("lk5_addr", r_mem_addr, 32'h400);
    step(); instr_req = 0; mem_gnt = 0; mem_rvalid = 1;
    smp();
    chk("lk6_data_rvalid", r_data_rvalid, 1);
    step();
    smp();
    chk("lk7_instr_rvalid", r_instr_rvalid, 1);
    step(); idle();

    // Locked master drops its request: the port goes idle for one cycle.
    step(); instr_req = 1; instr_addr = 32'h700;
    smp();
    chk("dr1_mem_req", mem_req, 1);
    step(); instr_req = 0; data_req = 1; data_addr = 32'h800;
    smp();
    chk("dr2_mem_req", mem_req, 0);
    chk("dr2_data_gnt", data_gnt, 0);
    step(); mem_gnt = 1;
    smp();
    chk("dr3_data_gnt", data_gnt, 1);
    chk("dr3_addr", mem_addr, 32'h800);
    step(); data_req = 0; mem_gnt = 0; mem_rvalid = 1;
    smp();
    chk("dr4_data_rvalid", data_rvalid, 1);
    step(); idle();

    // Outstanding limit of two.
    step(); instr_req = 1; instr_addr = 32'h900; mem_gnt = 1;
    smp();
    chk("mo1_gnt", instr_gnt, 1);
    step();
    smp();
    chk("mo2_gnt", instr_gnt, 1);
    step();
    smp();
    chk("mo3_gnt", instr_gnt, 0);
    chk("mo3_mem_req", mem_req, 0);
    step(); mem_rvalid = 1;
    smp();
    chk("mo4_gnt", instr_gnt, 0);
    chk("mo4_rvalid", instr_rvalid, 1);
    step(); mem_rvalid = 0;
    smp();
    chk("mo5_gnt", instr_gnt, 1);
    step(); instr_req = 0; mem_gnt = 0; mem_rvalid = 1;
    step();
    step(); idle();
    smp();
    chk("mo_proto", protocol_err, 0);

    // Response with nothing outstanding.
    step(); mem_rvalid = 1; mem_rdata = 32'hCAFE0000;
    smp();
    chk("pe_instr_rvalid", instr_rvalid, 0);
    chk("pe_data_rvalid", data_rvalid, 0);
    step(); mem_rvalid = 0;
    smp();
    chk("pe_set", protocol_err, 1);
    chk("pe_set_rr", r_protocol_err, 1);
    step();
    smp();
    chk("pe_hold", protocol_err, 1);
    step(); rst = 0;
    step(); rst = 1;
    smp();
    chk("pe_clear", protocol_err, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
